// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator feeding the Sobel kernel stage.
// Two circular line buffers feed a 3x3 shift register; windows leave through one output slot, zero-padded at the borders.

module sobel_window_gen #(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int PIX_W = 8,
  parameter int CW    = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [PIX_W-1:0]   s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [9*PIX_W-1:0] m_win,
  output logic [CW-1:0]      m_x,
  output logic [CW-1:0]      m_y,
  output logic               m_eof,
  output logic               frame_done
);

  localparam int AW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int FCW = CW + 1;
  localparam logic [CW-1:0]  X_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0]  Y_LAST  = CW'(IMG_H - 1);
  localparam logic [FCW-1:0] FLUSH_N = FCW'(IMG_W + 1);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t             state_q, state_d;
  logic               ready_en;
  logic               slot_free;
  logic               accept;
  logic               inject;
  logic               advance;
  logic               load_out;
  logic               frame_end;
  logic               flush_left;
  logic [CW-1:0]      in_x, in_y;
  logic [CW-1:0]      out_x, out_y;
  logic [FCW-1:0]     flush_cnt;
  logic [AW-1:0]      addr;
  logic [PIX_W-1:0]   pix_in;
  logic [PIX_W-1:0]   rd0, rd1;
  logic [PIX_W-1:0]   new_col [3];
  logic [9*PIX_W-1:0] win_q, win_d;
  logic [9*PIX_W-1:0] out_raw;

  // Line buffers: lb0 holds the previous line, lb1 the line before that.
  logic [PIX_W-1:0]   lb0 [IMG_W];
  logic [PIX_W-1:0]   lb1 [IMG_W];

  assign slot_free  = !m_valid || m_ready;
  assign accept     = s_valid && s_ready;
  assign flush_left = (flush_cnt != FLUSH_N);
  assign advance    = accept || inject;
  assign load_out   = (accept && (state_q == RUN)) || inject;
  assign pix_in     = inject ? '0 : s_data;
  assign addr       = in_x[AW-1:0];
  assign rd0        = lb0[addr];
  assign rd1        = lb1[addr];

  // ready_en keeps s_ready low while reset is asserted and for the first cycle after it.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is always updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise unassigned paths infer latches.
    state_d   = state_q;
    inject    = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept && (in_x == '0) && (in_y == CW'(1))) state_d = RUN;
      end
      RUN: begin
        if (accept && (in_x == X_LAST) && (in_y == Y_LAST)) state_d = FLUSH;
      end
      FLUSH: begin
        inject = flush_left && slot_free;
        if (!flush_left && m_valid && m_ready && m_eof) begin
          frame_end = 1'b1;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    unique case (state_q)
      FILL:    s_ready = ready_en;
      RUN:     s_ready = ready_en && slot_free;
      default: s_ready = 1'b0;
    endcase
  end

  // Input raster position doubles as the line-buffer address; it restarts at column 0 for each frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_x <= '0;
      in_y <= '0;
    end else if (frame_end) begin
      in_x <= '0;
      in_y <= '0;
    end else if (advance) begin
      if (in_x == X_LAST) begin
        in_x <= '0;
        in_y <= (in_y == Y_LAST) ? '0 : in_y + 1'b1;
      end else begin
        in_x <= in_x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  flush_cnt <= '0;
    else if (state_q != FLUSH)  flush_cnt <= '0;
    else if (inject)            flush_cnt <= flush_cnt + 1'b1;
  end

  // NOTE: the line-buffer RAMs carry no reset; stale contents only ever reach padded window positions.
  always_ff @(posedge clk) begin
    if (advance) begin
      lb0[addr] <= pix_in;
      lb1[addr] <= rd0;
    end
  end

  assign new_col[0] = rd1;
  assign new_col[1] = rd0;
  assign new_col[2] = pix_in;

  always_comb begin
    win_d = '0;
    for (int r = 0; r < 3; r++) begin
      win_d[PIX_W*(3*r)   +: PIX_W] = win_q[PIX_W*(3*r+1) +: PIX_W];
      win_d[PIX_W*(3*r+1) +: PIX_W] = win_q[PIX_W*(3*r+2) +: PIX_W];
      win_d[PIX_W*(3*r+2) +: PIX_W] = new_col[r];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        win_q <= '0;
    else if (advance) win_q <= win_d;
  end

  // Output slot: raw window plus the coordinates of its centre, loaded only when the slot is free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      out_raw <= '0;
      m_x     <= '0;
      m_y     <= '0;
      m_eof   <= 1'b0;
      out_x   <= '0;
      out_y   <= '0;
    end else begin
      if (load_out) begin
        m_valid <= 1'b1;
        out_raw <= win_d;
        m_x     <= out_x;
        m_y     <= out_y;
        m_eof   <= (out_x == X_LAST) && (out_y == Y_LAST);
        if (out_x == X_LAST) begin
          out_x <= '0;
          out_y <= (out_y == Y_LAST) ? '0 : out_y + 1'b1;
        end else begin
          out_x <= out_x + 1'b1;
        end
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_done <= 1'b0;
    else       frame_done <= frame_end;
  end

  // Border masking is applied on the way out so wrapped neighbours never leave the block.
  always_comb begin
    m_win = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!(((r == 0) && (m_y == '0))     || ((r == 2) && (m_y == Y_LAST)) ||
              ((c == 0) && (m_x == '0))     || ((c == 2) && (m_x == X_LAST))))
          m_win[PIX_W*(3*r+c) +: PIX_W] = out_raw[PIX_W*(3*r+c) +: PIX_W];
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x3 image: window contents, padding,
// latency, backpressure stability, mid-frame reset, back-to-back frames and input gaps.

module tb_sobel_window_gen;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PW = 8;
  localparam int CW = 10;
  localparam int N  = W * H;

  logic            clk = 1'b0;
  logic            reset;
  logic            s_valid;
  logic            s_ready;
  logic [PW-1:0]   s_data;
  logic            m_valid;
  logic            m_ready;
  logic [9*PW-1:0] m_win;
  logic [CW-1:0]   m_x;
  logic [CW-1:0]   m_y;
  logic            m_eof;
  logic            frame_done;

  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_win      (m_win),
    .m_x        (m_x),
    .m_y        (m_y),
    .m_eof      (m_eof),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0]   pix;
    int              x;
    int              y;
    logic [9*PW-1:0] win;
    logic            eof;
  } vec_t;

  typedef struct {
    logic [9*PW-1:0] win;
    logic [CW-1:0]   x;
    logic [CW-1:0]   y;
    logic            eof;
  } win_t;

  vec_t vecs [N];
  int   img  [N];
  win_t got_q [$];

  int tests = 0;
  int fails = 0;
  int fd_count = 0;
  int acc_cnt = 0;
  int first_acc = 0;
  bit first_seen = 0;
  bit first_prev_hs = 0;
  bit prev_hs = 0;
  bit chk_stall = 0;
  int stall_cnt = 0;
  int rdy_mode = 0;
  int rcnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Geometric reference: neighbours outside the image read as zero.
  function automatic logic [9*PW-1:0] ref_win(input int cx, input int cy);
    logic [9*PW-1:0] w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        int yy = cy + r - 1;
        int xx = cx + c - 1;
        if (yy >= 0 && yy < H && xx >= 0 && xx < W)
          w[PW*(3*r+c) +: PW] = PW'(img[yy*W + xx]);
      end
    return w;
  endfunction

  function automatic logic [9*PW-1:0] mk9(input int p0, input int p1, input int p2,
                                          input int p3, input int p4, input int p5,
                                          input int p6, input int p7, input int p8);
    return {PW'(p8), PW'(p7), PW'(p6), PW'(p5), PW'(p4), PW'(p3), PW'(p2), PW'(p1), PW'(p0)};
  endfunction

  function automatic void build_vecs();
    for (int i = 0; i < N; i++) begin
      vecs[i].pix = PW'(img[i]);
      vecs[i].x   = i % W;
      vecs[i].y   = i / W;
      vecs[i].win = ref_win(i % W, i / W);
      vecs[i].eof = (i == N - 1);
    end
  endfunction

  // Output monitor: samples on the falling edge, between active edges.
  initial begin
    logic [9*PW-1:0] pw;
    logic [CW-1:0]   px, py;
    bit              prev_stall;
    prev_stall = 0;
    pw = '0; px = '0; py = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        got_q.delete();
        fd_count = 0; acc_cnt = 0; first_seen = 0; prev_hs = 0; prev_stall = 0; stall_cnt = 0;
      end else begin
        if (m_valid && !first_seen) begin
          first_seen    = 1;
          first_acc     = acc_cnt;
          first_prev_hs = prev_hs;
        end
        if (chk_stall && prev_stall)
          check("stall_hold", 128'({m_win, m_x, m_y}), 128'({pw, px, py}));
        if (chk_stall && m_valid && !m_ready) begin
          stall_cnt++;
          check("stall_s_ready_low", 128'(s_ready), 128'(0));
        end
        if (m_valid && m_ready) got_q.push_back('{m_win, m_x, m_y, m_eof});
        if (frame_done) fd_count++;
        prev_stall = m_valid && !m_ready;
        pw = m_win; px = m_x; py = m_y;
        prev_hs = s_valid && s_ready;
        if (prev_hs) acc_cnt++;
      end
    end
  end

  // Downstream ready: always 1, or the repeating pattern 1,0,0,1.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rcnt++;
      if (rdy_mode == 0) m_ready = 1'b1;
      else               m_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
    end
  end

  task automatic do_reset();
    s_valid = 1'b0;
    s_data  = '0;
    reset   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 128'({s_ready, m_valid, m_eof, frame_done, m_x, m_y}), 128'(0));
    check("reset_m_win", 128'(m_win), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send_pixel(input logic [PW-1:0] v);
    int n = 0;
    s_valid = 1'b1;
    s_data  = v;
    @(negedge clk);
    while (!s_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("s_ready_timeout", 128'(s_ready), 128'(1));
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic stream(input int n, input int gapmax);
    for (int i = 0; i < n; i++) begin
      send_pixel(vecs[i % N].pix);
      if (gapmax > 0) idle($urandom_range(0, gapmax));
    end
  endtask

  task automatic wait_done(input string name, input int target);
    int n = 0;
    while (fd_count < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_frame_done_reached"}, 128'(fd_count >= target), 128'(1));
    repeat (4) @(negedge clk);
  endtask

  task automatic compare_frame(input string name, input int base, input int n);
    check({name, "_enough_windows"}, 128'(got_q.size() >= base + n), 128'(1));
    for (int i = 0; i < n; i++) begin
      if (base + i < got_q.size()) begin
        win_t g;
        g = got_q[base + i];
        check($sformatf("%s_w%0d", name, i),
              128'({g.x, g.y, g.eof, g.win}),
              128'({CW'(vecs[i].x), CW'(vecs[i].y), vecs[i].eof, vecs[i].win}));
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;

    // 1: plain stream 1..12, always ready.
    for (int i = 0; i < N; i++) img[i] = i + 1;
    build_vecs();
    rdy_mode = 0;
    do_reset();
    stream(N, 0);
    wait_done("s1", 1);
    compare_frame("s1", 0, N);
    check("s1_count", 128'(got_q.size()), 128'(N));
    if (got_q.size() == N) begin
      check("s1_win_0_0", 128'(got_q[0].win),  128'(mk9(0, 0, 0, 0, 1, 2, 0, 5, 6)));
      check("s1_win_1_1", 128'(got_q[5].win),  128'(mk9(1, 2, 3, 5, 6, 7, 9, 10, 11)));
      check("s1_win_3_2", 128'({got_q[11].eof, got_q[11].win}),
            128'({1'b1, mk9(7, 8, 0, 11, 12, 0, 0, 0, 0)}));
    end
    check("s1_frame_done_once", 128'(fd_count), 128'(1));
    check("s1_idle_after", 128'({m_valid, s_ready}), 128'(2'b01));

    // 3: first window appears right after input index 5 is accepted.
    check("s3_first_valid_latency", 128'({first_prev_hs, 32'(first_acc)}), 128'({1'b1, 32'd6}));

    // 2: backpressure pattern 1,0,0,1.
    do_reset();
    rdy_mode  = 1;
    chk_stall = 1;
    stream(N, 0);
    wait_done("s2", 1);
    chk_stall = 0;
    rdy_mode  = 0;
    compare_frame("s2", 0, N);
    check("s2_count", 128'(got_q.size()), 128'(N));
    check("s2_stalls_seen", 128'(stall_cnt != 0), 128'(1));
    check("s2_frame_done_once", 128'(fd_count), 128'(1));

    // 4: reset after 7 pixels, then a fresh frame 100..111.
    for (int i = 0; i < N; i++) img[i] = 50 + i;
    build_vecs();
    do_reset();
    stream(7, 0);
    do_reset();
    for (int i = 0; i < N; i++) img[i] = 100 + i;
    build_vecs();
    stream(N, 0);
    wait_done("s4", 1);
    compare_frame("s4", 0, N);
    check("s4_count", 128'(got_q.size()), 128'(N));
    if (got_q.size() > 0)
      check("s4_win_0_0", 128'(got_q[0].win), 128'(mk9(0, 0, 0, 0, 100, 101, 0, 104, 105)));

    // 5: two back-to-back frames of constant 255.
    for (int i = 0; i < N; i++) img[i] = 255;
    build_vecs();
    do_reset();
    stream(2 * N, 0);
    wait_done("s5", 2);
    compare_frame("s5a", 0, N);
    compare_frame("s5b", N, N);
    check("s5_count", 128'(got_q.size()), 128'(2 * N));
    check("s5_frame_done_twice", 128'(fd_count), 128'(2));
    if (got_q.size() == 2 * N) begin
      check("s5_interior", 128'(got_q[N + 5].win), 128'({9{8'hff}}));
      check("s5_corner_0_0", 128'(got_q[N].win), 128'(mk9(0, 0, 0, 0, 255, 255, 0, 255, 255)));
      check("s5_edge_3_1", 128'(got_q[7].win), 128'(mk9(255, 255, 0, 255, 255, 0, 255, 255, 0)));
    end

    // 6: random input gaps in FILL and RUN.
    for (int i = 0; i < N; i++) img[i] = i + 1;
    build_vecs();
    do_reset();
    stream(N, 3);
    wait_done("s6", 1);
    compare_frame("s6", 0, N);
    check("s6_count", 128'(got_q.size()), 128'(N));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
